dmem_cache: RTL and testbench



---
 rtl/dmem_cache_pkg.sv | 7 +
 rtl/dmem_backing.sv | 23 ++
 rtl/dmem_cache.sv | 96 +++++++++
 tb/tb_dmem_cache.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dmem_cache_pkg.sv
// Shared widths and defaults for the data cache and its backing store.
package dmem_cache_pkg;
    localparam int ADDR_W             = 16;
    localparam int DATA_W             = 32;
    localparam int DEFAULT_INDEX_BITS = 6;
    localparam int CNT_W              = 32;
endpackage

// File: rtl/dmem_backing.sv
// Word-addressed backing store: asynchronous read, synchronous write, no reset.
module dmem_backing
    import dmem_cache_pkg::*;
#(
    parameter int MEM_WORDS = 65536
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Write port: stores land at the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[32'(addr)] <= wdata;
        end
    end

    assign rdata = mem[32'(addr)];
endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Read misses are filled only when the pipeline pulses copy.
module dmem_cache
    import dmem_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int MEM_WORDS  = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              copy,
    output logic [DATA_W-1:0] read_data,
    output logic              hit,
    output logic [CNT_W-1:0]  fill_count,
    output logic [CNT_W-1:0]  write_count
);
    localparam int TAG_W = ADDR_W - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [LINES-1:0]      valid_reg;
    logic [TAG_W-1:0]      tag_ram  [LINES];
    logic [DATA_W-1:0]     data_ram [LINES];
    logic [DATA_W-1:0]     backing_rdata;
    logic [CNT_W-1:0]      fill_count_reg;
    logic [CNT_W-1:0]      write_count_reg;
    logic                  do_write;
    logic                  do_copy;

    assign idx = address[INDEX_BITS-1:0];
    assign tag = address[ADDR_W-1:INDEX_BITS];

    // Requests arriving during reset are dropped entirely.
    assign do_write = write && !reset;
    assign do_copy  = copy && !reset;

    dmem_backing #(
        .MEM_WORDS (MEM_WORDS)
    ) u_backing (
        .clk   (clk),
        .we    (do_write),
        .addr  (address),
        .wdata (write_data),
        .rdata (backing_rdata)
    );

    assign hit       = valid_reg[idx] && (tag_ram[idx] == tag);
    assign read_data = hit ? data_ram[idx] : backing_rdata;

    // Per-line valid bit: cleared by reset, set by a fill of that line.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (do_copy && (idx == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data arrays: fills allocate, store hits update data only.
    // A simultaneous store+fill takes write_data, since the backing read
    // still shows the pre-store word in that cycle.
    always_ff @(posedge clk) begin
        if (do_copy) begin
            tag_ram[idx]  <= tag;
            data_ram[idx] <= do_write ? write_data : backing_rdata;
        end else if (do_write && hit) begin
            data_ram[idx] <= write_data;
        end
    end

    // Activity counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_count_reg  <= '0;
            write_count_reg <= '0;
        end else begin
            if (do_copy) begin
                fill_count_reg <= fill_count_reg + 1'b1;
            end
            if (do_write) begin
                write_count_reg <= write_count_reg + 1'b1;
            end
        end
    end

    assign fill_count  = fill_count_reg;
    assign write_count = write_count_reg;
endmodule

// File: tb/tb_dmem_cache.sv
// Scoreboard bench for dmem_cache: stimulus pushes expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_cache;
    import dmem_cache_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              write = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              copy = 1'b0;
    logic [DATA_W-1:0] read_data;
    logic              hit;
    logic [CNT_W-1:0]  fill_count;
    logic [CNT_W-1:0]  write_count;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  fills;
        logic [CNT_W-1:0]  writes;
    } exp_t;

    exp_t sb_q[$];
    logic check_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dmem_cache #(
        .INDEX_BITS (6),
        .MEM_WORDS  (65536)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .address     (address),
        .write_data  (write_data),
        .copy        (copy),
        .read_data   (read_data),
        .hit         (hit),
        .fill_count  (fill_count),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle whenever a check is requested.
    always @(negedge clk) begin
        if (check_req) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: check requested with empty queue");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                cmp(e.name, "addr", 32'(address), 32'(e.addr));
                cmp(e.name, "hit", 32'(hit), 32'(e.hit));
                cmp(e.name, "read_data", read_data, e.data);
                cmp(e.name, "fill_count", fill_count, e.fills);
                cmp(e.name, "write_count", write_count, e.writes);
                $display("txn %-14s addr=%h hit=%0d data=%h fills=%0d writes=%0d",
                         e.name, address, hit, read_data, fill_count, write_count);
            end
        end
    end

    // One clock with the given request; inputs return to idle afterwards.
    task automatic op(input logic [15:0] a, input logic w, input logic [31:0] wd,
                      input logic cp);
        address = a; write = w; write_data = wd; copy = cp;
        @(posedge clk); #1;
        write = 1'b0; copy = 1'b0;
    endtask

    // Idle read cycle with an expected observation queued for the monitor.
    task automatic check(input string name, input logic [15:0] a, input logic h,
                         input logic [31:0] d, input logic [31:0] f, input logic [31:0] wc);
        exp_t e;
        e.name = name; e.addr = a; e.hit = h; e.data = d; e.fills = f; e.writes = wc;
        sb_q.push_back(e);
        address = a; write = 1'b0; copy = 1'b0;
        check_req = 1'b1;
        @(posedge clk); #1;
        check_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        // Preload the backing store through store misses, then clear counters.
        op(16'h0010, 1'b1, 32'hDEADBEEF, 1'b0);
        op(16'h0020, 1'b1, 32'h00000000, 1'b0);
        op(16'h0005, 1'b1, 32'h11110005, 1'b0);
        op(16'h0045, 1'b1, 32'h22220045, 1'b0);
        op(16'h0030, 1'b1, 32'h00000000, 1'b0);
        op(16'h0011, 1'b1, 32'h33330011, 1'b0);
        op(16'h0050, 1'b1, 32'h44440050, 1'b0);
        do_reset();

        // Read miss then fill after the two-cycle stall.
        check("reset_miss", 16'h0010, 1'b0, 32'hDEADBEEF, 0, 0);
        op(16'h0010, 1'b0, 32'h0, 1'b0);
        op(16'h0010, 1'b0, 32'h0, 1'b1);
        check("filled_hit", 16'h0010, 1'b1, 32'hDEADBEEF, 1, 0);

        // Store miss: write-through, no allocation.
        op(16'h0020, 1'b1, 32'h12345678, 1'b0);
        check("store_miss", 16'h0020, 1'b0, 32'h12345678, 1, 1);
        check("no_alloc", 16'h0020, 1'b0, 32'h12345678, 1, 1);

        // Store hit updates the line and the backing store.
        op(16'h0010, 1'b1, 32'hCAFEF00D, 1'b0);
        check("store_hit", 16'h0010, 1'b1, 32'hCAFEF00D, 1, 2);
        op(16'h0050, 1'b0, 32'h0, 1'b1);
        check("evict_fill", 16'h0050, 1'b1, 32'h44440050, 2, 2);
        check("backing_wt", 16'h0010, 1'b0, 32'hCAFEF00D, 2, 2);

        // Conflict eviction on index 5.
        op(16'h0005, 1'b0, 32'h0, 1'b1);
        op(16'h0045, 1'b0, 32'h0, 1'b1);
        check("conflict_old", 16'h0005, 1'b0, 32'h11110005, 4, 2);
        check("conflict_new", 16'h0045, 1'b1, 32'h22220045, 4, 2);

        // Simultaneous store and fill, then a redundant fill while hitting.
        op(16'h0030, 1'b1, 32'hA5A5A5A5, 1'b1);
        check("write_copy", 16'h0030, 1'b1, 32'hA5A5A5A5, 5, 3);
        op(16'h0030, 1'b0, 32'h0, 1'b1);
        check("refill_hit", 16'h0030, 1'b1, 32'hA5A5A5A5, 6, 3);

        // Reset in the middle of a pending miss; requests during reset ignored.
        op(16'h0010, 1'b0, 32'h0, 1'b1);
        check("pre_reset_hit", 16'h0010, 1'b1, 32'hCAFEF00D, 7, 3);
        check("miss_start", 16'h0011, 1'b0, 32'h33330011, 7, 3);
        address = 16'h0011; write = 1'b1; write_data = 32'hFFFFFFFF; copy = 1'b1;
        do_reset();
        write = 1'b0; copy = 1'b0;
        check("post_reset", 16'h0010, 1'b0, 32'hCAFEF00D, 0, 0);
        check("reset_ignored", 16'h0011, 1'b0, 32'h33330011, 0, 0);
        op(16'h0011, 1'b0, 32'h0, 1'b1);
        check("fill_after_rst", 16'h0011, 1'b1, 32'h33330011, 1, 0);

        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
